nibble_serial_adder: RTL and testbench

Multi-cycle wide adder that feeds the team's 4-bit ripple adder slice one nibble per clock and collects its outputs. It accepts a WIDTH-bit operand pair over a valid/ready handshake, carries between nibbles in a register, and presents the registered WIDTH-bit sum and final carry on a valid/ready output. It sits between operand producers and result consumers wherever a wide add is needed but only one 4-bit slice can be spent.

---
 rtl/nibble_add_pkg.sv | 18 +
 rtl/fullbit4.sv | 23 ++
 rtl/nibble_serial_adder.sv | 127 ++++++++++++
 tb/tb_nibble_serial_adder.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/nibble_add_pkg.sv
// Shared definitions for the nibble-serial adder: slice width, FSM states and
// the index-counter width helper.
package nibble_add_pkg;

    localparam int unsigned NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // A single-nibble build still needs a 1-bit index register.
    function automatic int unsigned idx_width(input int unsigned nibbles);
        return (nibbles <= 1) ? 1 : $clog2(nibbles);
    endfunction

endpackage

// File: rtl/fullbit4.sv
// 4-bit ripple-carry adder slice used as the shared datapath of the serial adder.
module fullbit4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] c;

    always_comb begin
        sum  = '0;
        c    = '0;
        c[0] = cin;
        for (int unsigned i = 0; i < 4; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout = c[4];
    end

endmodule

// File: rtl/nibble_serial_adder.sv
// Wide adder that pushes one nibble per clock through a single fullbit4 slice.
// Optional subtract mode is enabled with the NSA_SUB_EN macro.
module nibble_serial_adder
    import nibble_add_pkg::*;
#(
    parameter int unsigned NIBBLES = 4,
    localparam int unsigned WIDTH  = NIBBLE_W * NIBBLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
`ifdef NSA_SUB_EN
    ,
    input  logic             sub
`endif
);

    localparam int unsigned IDX_W = idx_width(NIBBLES);

    state_t              state, state_n;
    logic [WIDTH-1:0]    a_q, b_q;
    logic                carry_q;
    logic [IDX_W-1:0]    idx;
    logic [NIBBLE_W-1:0] a_nib, b_nib, b_slice, slice_sum;
    logic                slice_cout;
    logic                accept, last;
    logic                init_carry;

`ifdef NSA_SUB_EN
    logic sub_q;
    assign init_carry = sub ? 1'b1 : c_in;
    assign b_slice    = b_nib ^ {NIBBLE_W{sub_q}};
`else
    assign init_carry = c_in;
    assign b_slice    = b_nib;
`endif

    assign accept = in_valid && in_ready;
    assign last   = (idx == IDX_W'(NIBBLES - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_n = RUN;
            end
            RUN: begin
                if (last) state_n = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Select the active nibble by compare rather than a variable part-select so
    // no out-of-range index is ever formed.
    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int unsigned n = 0; n < NIBBLES; n++) begin
            if (idx == IDX_W'(n)) begin
                a_nib = a_q[n*NIBBLE_W +: NIBBLE_W];
                b_nib = b_q[n*NIBBLE_W +: NIBBLE_W];
            end
        end
    end

    fullbit4 u_slice (
        .a    (a_nib),
        .b    (b_slice),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx     <= '0;
            sum     <= '0;
            c_out   <= 1'b0;
`ifdef NSA_SUB_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            if (accept) begin
                a_q     <= a;
                b_q     <= b;
                carry_q <= init_carry;
                idx     <= '0;
`ifdef NSA_SUB_EN
                sub_q   <= sub;
`endif
            end
            if (state == RUN) begin
                for (int unsigned n = 0; n < NIBBLES; n++) begin
                    if (idx == IDX_W'(n)) sum[n*NIBBLE_W +: NIBBLE_W] <= slice_sum;
                end
                carry_q <= slice_cout;
                if (last) c_out <= slice_cout;
                else      idx   <= idx + IDX_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder: expected {c_out,sum} values are
// queued at the accept edge and compared when the result is presented.
module tb_nibble_serial_adder;

    localparam int unsigned N = 4;
    localparam int unsigned W = 4 * N;

    typedef logic [W:0] res_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a, b;
    logic         c_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         c_out;
    logic         sub;

    int   checks = 0;
    int   errors = 0;
    res_t exp_q[$];

    always #5 clk = ~clk;

    nibble_serial_adder #(.NIBBLES(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out)
`ifdef NSA_SUB_EN
        ,
        .sub       (sub)
`endif
    );

    function automatic res_t model(input logic [W-1:0] aa, input logic [W-1:0] bb,
                                   input logic ci, input logic s);
        res_t r;
        if (s) r = {1'b0, aa} + {1'b0, ~bb} + res_t'(1);
        else   r = {1'b0, aa} + {1'b0, bb} + res_t'(ci);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one accept edge from IDLE, then scrambles the operands.
    task automatic accept(input logic [W-1:0] aa, input logic [W-1:0] bb,
                          input logic ci, input logic s);
        a = aa; b = bb; c_in = ci; sub = s; in_valid = 1'b1;
        exp_q.push_back(model(aa, bb, ci, s));
        tick();
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); c_in = 1'($urandom); sub = 1'($urandom);
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
        tick(); tick();
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs: in_ready=%b out_valid=%b, expected 1 0", in_ready, out_valid);
        end
        checks++;
        if (sum !== '0 || c_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_data: sum=%h c_out=%b, expected 0 0", sum, c_out);
        end
    endtask

    task automatic run_one(input string name, input logic [W-1:0] aa, input logic [W-1:0] bb,
                           input logic ci, input logic s);
        res_t e;
        out_ready = 1'b1;
        accept(aa, bb, ci, s);
        for (int unsigned k = 1; k <= N; k++) begin
            tick();
            checks++;
            if (out_valid !== (k == N) || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s_latency: cycle %0d out_valid=%b in_ready=%b, expected %b 0",
                         name, k, out_valid, in_ready, (k == N));
            end
        end
        e = exp_q.pop_front();
        checks++;
        if ({c_out, sum} !== e) begin
            errors++;
            $display("FAIL %s_result: got %h, expected %h", name, {c_out, sum}, e);
        end
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle: in_ready=%b out_valid=%b, expected 1 0", name, in_ready, out_valid);
        end
    endtask

    task automatic test_add();
        run_one("add_5555", 16'h1234, 16'h4321, 1'b0, 1'b0);
        run_one("add_ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        run_one("add_cin", 16'hFFFF, 16'h0000, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++)
            run_one("add_rand", W'($urandom), W'($urandom), 1'($urandom), 1'b0);
    endtask

    task automatic test_backpressure();
        res_t e;
        out_ready = 1'b0;
        accept(16'h00FF, 16'h0001, 1'b0, 1'b0);
        e = exp_q.pop_front();
        for (int unsigned k = 1; k <= N; k++) tick();
        in_valid = 1'b1; a = 16'hAAAA; b = 16'h5555;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || {c_out, sum} !== e) begin
                errors++;
                $display("FAIL bp_hold: cycle %0d out_valid=%b in_ready=%b res=%h, expected 1 0 %h",
                         k, out_valid, in_ready, {c_out, sum}, e);
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || e !== 17'h00100) begin
            errors++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b model=%h, expected 1 0 00100",
                     in_ready, out_valid, e);
        end
        // The held in_valid above must not have been taken while in DONE.
        tick();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_no_accept: in_ready=%b, expected 1", in_ready);
        end
    endtask

    task automatic test_back_to_back();
        int   second_acc = -1;
        int   results = 0;
        res_t e;
        out_ready = 1'b1;
        a = 16'h0F0F; b = 16'h0101; c_in = 1'b1; sub = 1'b0; in_valid = 1'b1;
        exp_q.push_back(model(16'h0F0F, 16'h0101, 1'b1, 1'b0));
        tick();
        a = 16'h8000; b = 16'h8001; c_in = 1'b0;
        exp_q.push_back(model(16'h8000, 16'h8001, 1'b0, 1'b0));
        for (int cyc = 1; cyc <= 3 * N + 6; cyc++) begin
            if (out_valid === 1'b1) begin
                e = exp_q.pop_front();
                results++;
                checks++;
                if ({c_out, sum} !== e) begin
                    errors++;
                    $display("FAIL b2b_result%0d: got %h, expected %h", results, {c_out, sum}, e);
                end
            end
            if (in_valid && in_ready === 1'b1 && second_acc < 0) second_acc = cyc;
            tick();
            if (second_acc >= 0) in_valid = 1'b0;
        end
        checks++;
        if (second_acc != int'(N + 2) || results != 2) begin
            errors++;
            $display("FAIL b2b_spacing: second accept at %0d with %0d results, expected %0d and 2",
                     second_acc, results, N + 2);
        end
    endtask

    task automatic test_reset_mid_run();
        out_ready = 1'b1;
        a = 16'h1234; b = 16'h1111; c_in = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || sum !== '0 || c_out !== 1'b0) begin
            errors++;
            $display("FAIL rst_run: out_valid=%b in_ready=%b sum=%h c_out=%b, expected 0 1 0 0",
                     out_valid, in_ready, sum, c_out);
        end
        for (int k = 0; k < int'(N) + 2; k++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL rst_discard: cycle %0d out_valid=%b, expected 0", k, out_valid);
            end
        end
        run_one("rst_fresh", 16'h0001, 16'h0001, 1'b0, 1'b0);
    endtask

`ifdef NSA_SUB_EN
    task automatic test_sub();
        run_one("sub_neg", 16'h0005, 16'h0007, 1'b1, 1'b1);
        run_one("sub_pos", 16'h0007, 16'h0005, 1'b0, 1'b1);
        run_one("sub_off", 16'h1234, 16'h4321, 1'b1, 1'b0);
    endtask
`endif

    initial begin
        test_reset();
        test_add();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_run();
`ifdef NSA_SUB_EN
        test_sub();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
